multicycle_ctrl: RTL and testbench
==================================

# multicycle_ctrl

Multicycle controller that sequences a shared-ALU ARM-subset datapath (ADD, SUB, AND, ORR, LDR, STR, B) over 3–5 cycles per instruction. Consumes instruction fields from the instruction register and ALU flags. Drives every enable and mux select of the multicycle datapath. Holds the NZCV flag register and applies ARM condition codes.

## Interface
- none (fixed ISA subset; no parameters)

- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low; asserted when 0
- Cond  in  4  Instr[31:28]
- Op  in  2  Instr[27:26]
- Funct  in  6  Instr[25:20] (I, cmd[3:0], S/L)
- Rd  in  4  Instr[15:12]
- ALUFlags  in  4  {N,Z,C,V} from ALU, current cycle
- PCWrite  out  1  load PC with Result
- AdrSrc  out  1  memory address: 0=PC, 1=Result
- MemWrite  out  1  data memory write strobe
- IRWrite  out  1  load instruction register
- ResultSrc  out  2  00=ALUOut reg, 01=Data reg, 10=ALUResult
- ALUControl  out  2  00 ADD, 01 SUB, 10 AND, 11 ORR
- ALUSrcA  out  1  0=RD1, 1=PC
- ALUSrcB  out  2  00=RD2, 01=ExtImm, 10=constant 4
- ImmSrc  out  2  equals Op
- RegSrc  out  2  [0]=(Op==10) selects R15 for RA1; [1]=(Op==01) selects Rd for RA2
- RegWrite  out  1  register file write enable

## Operation
- State register, 10 states: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH.
- Transitions: FETCH→DECODE. DECODE: Op=00,Funct[5]=0→EXECR; Op=00,Funct[5]=1→EXECI; Op=01→MEMADR; Op=10→BRANCH; Op=11→FETCH (undefined, no writes). MEMADR: Funct[0]=1→MEMRD else MEMWR. MEMRD→MEMWB→FETCH. MEMWR→FETCH. EXECR/EXECI→ALUWB→FETCH. BRANCH→FETCH.
- Per-state raw controls (unlisted = 0 / 00):
  - FETCH: IRWrite, NextPC, ALUSrcA=1, ALUSrcB=10, ResultSrc=10, ALU ADD.
  - DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10, ADD (produces PC+8 for R15 reads).
  - MEMADR: ALUSrcB=01, ADD. MEMRD: AdrSrc=1. MEMWB: ResultSrc=01, RegW. MEMWR: AdrSrc=1, MemW.
  - EXECR: ALUSrcB=00, ALUOp. EXECI: ALUSrcB=01, ALUOp. ALUWB: RegW.
  - BRANCH: ALUSrcB=01, ResultSrc=10, ADD, Branch.
- ALU decode when ALUOp: Funct[4:1] 0100→00, 0010→01, 0000→10, 1100→11, other→00 with no flag write. Without ALUOp: 00.
- FlagW: ALUOp & Funct[0]: ADD/SUB→{NZ,CV}; AND/ORR→NZ only.
- Condition: CondEx per ARM table over flag register (EQ,NE,CS,CC,MI,PL,VS,VC,HI,LS,GE,LT,GT,LE,AL); Cond=1111 → 0. Latched into cond_ok at end of DECODE; later states use cond_ok only.
- Gated outputs: RegWrite=RegW&cond_ok; MemWrite=MemW&cond_ok; PCWrite=NextPC | ((Branch | (RegW & Rd==1111)) & cond_ok).
- Flag register update at end of EXECR/EXECI when cond_ok: NZ if FlagW[1], CV if FlagW[0], from ALUFlags.

## Timing
- Reset (reset==0 at rising edge): state←FETCH, flags←0000, cond_ok←0. While reset==0, PCWrite, IRWrite, MemWrite, RegWrite forced 0; selects take FETCH values.
- Outputs Moore from state plus registered cond_ok; no combinational path from ALUFlags to any output.
- Latency: data-processing 4 cycles, LDR 5, STR 4, B 3, undefined 2.
- Failed condition: instruction still walks all its states; RegWrite, MemWrite, conditional PCWrite and flag update suppressed. PC has already advanced by 4 in FETCH.
- Flags written in EXECx are not visible to this instruction's CondEx (cond_ok already latched). They are visible to the next instruction's DECODE.
- Reset low mid-instruction: abandon instruction next edge; no partial write after that edge.

## Test plan
- Reset low 2 cycles, release → FETCH with PCWrite=1, IRWrite=1, ALUSrcB=10, ResultSrc=10. Write enables are 0 during reset.
- ADDS R1,R2,R3 (E0921003), ALUFlags=0100 in EXECR → states F,D,ER,AW. ALUControl=00. Flags=0100 after EXECR. RegWrite=1 only in ALUWB.
- SUBS giving Z=1, then BEQ (0A000002) → 3-cycle branch with PCWrite=1 in BRANCH. BNE instead → PCWrite=0 in BRANCH.
- LDR R0,[R1,#4] (E5910004) → F,D,MA,MR,MWB. AdrSrc=1 in MR. ResultSrc=01 and RegWrite=1 in MWB. STR (E5810004) → MemWrite=1 only in MEMWR.
- ORR with Rd=1111 (E18CF002), AL → PCWrite=1 and RegWrite=1 in ALUWB. Same instruction with Cond=0000 while Z=0 → both 0, flags unchanged.
- Op=11 word → FETCH,DECODE,FETCH with no writes. Reset low during MEMRD → next state FETCH, no RegWrite.

Source files
------------

// File: rtl/multicycle_ctrl_if.sv
// Control/status bundle between the multicycle controller (master) and the
// datapath that supplies instruction fields and ALU flags (slave).
interface multicycle_ctrl_if;
   logic [3:0] Cond;
   logic [1:0] Op;
   logic [5:0] Funct;
   logic [3:0] Rd;
   logic [3:0] ALUFlags;
   logic       PCWrite;
   logic       AdrSrc;
   logic       MemWrite;
   logic       IRWrite;
   logic [1:0] ResultSrc;
   logic [1:0] ALUControl;
   logic       ALUSrcA;
   logic [1:0] ALUSrcB;
   logic [1:0] ImmSrc;
   logic [1:0] RegSrc;
   logic       RegWrite;

   modport master (
      input  Cond, Op, Funct, Rd, ALUFlags,
      output PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUControl,
             ALUSrcA, ALUSrcB, ImmSrc, RegSrc, RegWrite
   );

   modport slave (
      output Cond, Op, Funct, Rd, ALUFlags,
      input  PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUControl,
             ALUSrcA, ALUSrcB, ImmSrc, RegSrc, RegWrite
   );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multicycle controller for an ARM-subset datapath: sequences FETCH..writeback,
// holds NZCV and gates writes with the condition latched in DECODE.
module multicycle_ctrl (
   input  logic              clk,
   input  logic              reset,
   multicycle_ctrl_if.master bus
);
   typedef enum logic [3:0] {
      FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH
   } state_t;

   typedef struct packed {
      logic       pc_write;
      logic       adr_src;
      logic       mem_write;
      logic       ir_write;
      logic [1:0] result_src;
      logic [1:0] alu_control;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic       reg_write;
   } ctrl_t;

   localparam ctrl_t RESET_CTRL = '{
      pc_write: 1'b0, adr_src: 1'b0, mem_write: 1'b0, ir_write: 1'b0,
      result_src: 2'b10, alu_control: 2'b00, alu_src_a: 1'b1,
      alu_src_b: 2'b10, reg_write: 1'b0
   };

   state_t     state;
   state_t     next;
   logic [3:0] flags;
   logic       cond_ok;
   logic       cond_next;
   logic [1:0] flag_w;
   ctrl_t      ctrl;
   ctrl_t      ctrl_out;

   function automatic logic cond_ex(input logic [3:0] cond, input logic [3:0] f);
      logic n, z, c, v;
      {n, z, c, v} = f;
      case (cond)
         4'b0000: cond_ex = z;
         4'b0001: cond_ex = !z;
         4'b0010: cond_ex = c;
         4'b0011: cond_ex = !c;
         4'b0100: cond_ex = n;
         4'b0101: cond_ex = !n;
         4'b0110: cond_ex = v;
         4'b0111: cond_ex = !v;
         4'b1000: cond_ex = c && !z;
         4'b1001: cond_ex = !c || z;
         4'b1010: cond_ex = (n == v);
         4'b1011: cond_ex = (n != v);
         4'b1100: cond_ex = !z && (n == v);
         4'b1101: cond_ex = z || (n != v);
         4'b1110: cond_ex = 1'b1;
         default: cond_ex = 1'b0;
      endcase
   endfunction

   function automatic logic [1:0] alu_sel(input logic [3:0] cmd);
      case (cmd)
         4'b0010: alu_sel = 2'b01;
         4'b0000: alu_sel = 2'b10;
         4'b1100: alu_sel = 2'b11;
         default: alu_sel = 2'b00;
      endcase
   endfunction

   function automatic state_t step(input state_t s, input logic [1:0] op,
                                   input logic [5:0] funct);
      case (s)
         FETCH:  step = DECODE;
         DECODE:
            case (op)
               2'b00:   step = funct[5] ? EXECI : EXECR;
               2'b01:   step = MEMADR;
               2'b10:   step = BRANCH;
               default: step = FETCH;
            endcase
         MEMADR: step = funct[0] ? MEMRD : MEMWR;
         MEMRD:  step = MEMWB;
         EXECR,
         EXECI:  step = ALUWB;
         default: step = FETCH;
      endcase
   endfunction

   // Controls for the state about to be entered, so outputs come straight from flops.
   function automatic ctrl_t ctrl_for(input state_t s, input logic ok,
                                      input logic [5:0] funct, input logic [3:0] rd);
      ctrl_t c;
      logic  regw;
      c    = '0;
      regw = 1'b0;
      case (s)
         FETCH: begin
            c.ir_write = 1'b1; c.pc_write = 1'b1; c.alu_src_a = 1'b1;
            c.alu_src_b = 2'b10; c.result_src = 2'b10;
         end
         DECODE: begin
            c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; c.result_src = 2'b10;
         end
         MEMADR: c.alu_src_b = 2'b01;
         MEMRD:  c.adr_src = 1'b1;
         MEMWB:  begin c.result_src = 2'b01; regw = 1'b1; end
         MEMWR:  begin c.adr_src = 1'b1; c.mem_write = ok; end
         EXECR:  c.alu_control = alu_sel(funct[4:1]);
         EXECI:  begin c.alu_src_b = 2'b01; c.alu_control = alu_sel(funct[4:1]); end
         ALUWB:  regw = 1'b1;
         BRANCH: begin c.alu_src_b = 2'b01; c.result_src = 2'b10; c.pc_write = ok; end
         default: c = '0;
      endcase
      c.reg_write = regw & ok;
      if (regw && ok && rd == 4'hF) c.pc_write = 1'b1;
      return c;
   endfunction

   always_comb begin
      next      = step(state, bus.Op, bus.Funct);
      cond_next = (state == DECODE) ? cond_ex(bus.Cond, flags) : cond_ok;
      flag_w    = 2'b00;
      if (bus.Funct[0]) begin
         case (bus.Funct[4:1])
            4'b0100, 4'b0010: flag_w = 2'b11;
            4'b0000, 4'b1100: flag_w = 2'b10;
            default:          flag_w = 2'b00;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state   <= FETCH;
         flags   <= '0;
         cond_ok <= 1'b0;
         ctrl    <= ctrl_for(FETCH, 1'b0, '0, '0);
      end else begin
         state   <= next;
         cond_ok <= cond_next;
         ctrl    <= ctrl_for(next, cond_next, bus.Funct, bus.Rd);
         if ((state == EXECR || state == EXECI) && cond_ok) begin
            if (flag_w[1]) flags[3:2] <= bus.ALUFlags[3:2];
            if (flag_w[0]) flags[1:0] <= bus.ALUFlags[1:0];
         end
      end
   end

   always_comb begin
      ctrl_out       = reset ? ctrl : RESET_CTRL;
      bus.PCWrite    = ctrl_out.pc_write;
      bus.AdrSrc     = ctrl_out.adr_src;
      bus.MemWrite   = ctrl_out.mem_write;
      bus.IRWrite    = ctrl_out.ir_write;
      bus.ResultSrc  = ctrl_out.result_src;
      bus.ALUControl = ctrl_out.alu_control;
      bus.ALUSrcA    = ctrl_out.alu_src_a;
      bus.ALUSrcB    = ctrl_out.alu_src_b;
      bus.RegWrite   = ctrl_out.reg_write;
      bus.ImmSrc     = bus.Op;
      bus.RegSrc     = {bus.Op == 2'b01, bus.Op == 2'b10};
   end
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Instruction-level bench: each instruction word expands into its expected
// per-cycle control vectors, with a shadow NZCV register.
module tb_multicycle_ctrl;
   logic clk = 1'b0;
   logic reset;
   int   total = 0;
   int   bad = 0;
   int   n_instr = 0;
   logic [3:0] model_flags = 4'h0;

   multicycle_ctrl_if bus ();

   multicycle_ctrl dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%b exp=%b", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] observed();
      return {bus.PCWrite, bus.AdrSrc, bus.MemWrite, bus.IRWrite, bus.ResultSrc,
              bus.ALUControl, bus.ALUSrcA, bus.ALUSrcB, bus.ImmSrc, bus.RegSrc,
              bus.RegWrite};
   endfunction

   function automatic logic [15:0] vec(input logic pcw, input logic adr, input logic memw,
                                       input logic irw, input logic [1:0] res,
                                       input logic [1:0] alu, input logic sa,
                                       input logic [1:0] sb, input logic regw,
                                       input logic [1:0] op);
      return {pcw, adr, memw, irw, res, alu, sa, sb, op, op == 2'b01, op == 2'b10, regw};
   endfunction

   // ARM pairs: even code tests a predicate, odd code its inverse.
   function automatic logic cond_true(input logic [3:0] cond, input logic [3:0] f);
      logic n, z, c, v, base;
      {n, z, c, v} = f;
      case (cond[3:1])
         3'd0: base = z;
         3'd1: base = c;
         3'd2: base = n;
         3'd3: base = v;
         3'd4: base = c & ~z;
         3'd5: base = (n == v);
         3'd6: base = ~z & (n == v);
         default: base = 1'b1;
      endcase
      if (cond == 4'hF) return 1'b0;
      return cond[0] ? ~base : base;
   endfunction

   function automatic logic [1:0] alu_code(input logic [3:0] cmd);
      if (cmd == 4'b0010) return 2'd1;
      if (cmd == 4'b0000) return 2'd2;
      if (cmd == 4'b1100) return 2'd3;
      return 2'd0;
   endfunction

   task automatic expect_reset(input string tag);
      @(negedge clk);
      check(tag, observed(), vec(0, 0, 0, 0, 2'b10, 2'b00, 1, 2'b10, 0, bus.Op));
   endtask

   // Entered just after the edge that begins FETCH; returns just after the
   // edge that begins the next FETCH.
   task automatic run_instr(input logic [31:0] w, input logic force_fl,
                            input logic [3:0] fl, input int abort_at);
      logic [15:0] seq[$];
      logic [1:0]  op;
      logic [3:0]  cmd, rd;
      logic        ok, s_bit;
      int          exec_idx;
      op    = w[27:26];
      cmd   = w[24:21];
      s_bit = w[20];
      rd    = w[15:12];
      bus.Cond  = w[31:28];
      bus.Op    = op;
      bus.Funct = w[25:20];
      bus.Rd    = rd;
      ok        = cond_true(w[31:28], model_flags);
      exec_idx  = -1;
      n_instr++;
      seq.push_back(vec(1, 0, 0, 1, 2'b10, 2'b00, 1, 2'b10, 0, op));
      seq.push_back(vec(0, 0, 0, 0, 2'b10, 2'b00, 1, 2'b10, 0, op));
      case (op)
         2'b00: begin
            exec_idx = 2;
            seq.push_back(vec(0, 0, 0, 0, 2'b00, alu_code(cmd), 0,
                              w[25] ? 2'b01 : 2'b00, 0, op));
            seq.push_back(vec(ok && rd == 4'hF, 0, 0, 0, 2'b00, 2'b00, 0, 2'b00, ok, op));
         end
         2'b01: begin
            seq.push_back(vec(0, 0, 0, 0, 2'b00, 2'b00, 0, 2'b01, 0, op));
            if (w[20]) begin
               seq.push_back(vec(0, 1, 0, 0, 2'b00, 2'b00, 0, 2'b00, 0, op));
               seq.push_back(vec(ok && rd == 4'hF, 0, 0, 0, 2'b01, 2'b00, 0, 2'b00, ok, op));
            end else begin
               seq.push_back(vec(0, 1, ok, 0, 2'b00, 2'b00, 0, 2'b00, 0, op));
            end
         end
         2'b10: seq.push_back(vec(ok, 0, 0, 0, 2'b10, 2'b00, 0, 2'b01, 0, op));
         default: ;
      endcase
      for (int i = 0; i < seq.size(); i++) begin
         if (i == abort_at) begin
            reset = 1'b0;
            expect_reset($sformatf("abort_i%0d_c%0d", n_instr, i));
            @(posedge clk); #1;
            expect_reset($sformatf("abort_hold_i%0d", n_instr));
            model_flags = 4'h0;
            @(posedge clk); #1;
            reset = 1'b1;
            return;
         end
         bus.ALUFlags = (force_fl && i == exec_idx) ? fl : 4'($urandom);
         @(negedge clk);
         check($sformatf("i%0d_%h_c%0d", n_instr, w, i), observed(), seq[i]);
         @(posedge clk);
         if (i == exec_idx && ok && s_bit) begin
            if (cmd == 4'b0100 || cmd == 4'b0010) model_flags = bus.ALUFlags;
            else if (cmd == 4'b0000 || cmd == 4'b1100)
               model_flags[3:2] = bus.ALUFlags[3:2];
         end
         #1;
      end
   endtask

   initial begin
      logic [31:0] w;
      reset        = 1'b0;
      bus.Cond     = '0;
      bus.Op       = '0;
      bus.Funct    = '0;
      bus.Rd       = '0;
      bus.ALUFlags = '0;
      #1;
      check("rst_async_view", observed(), vec(0, 0, 0, 0, 2'b10, 2'b00, 1, 2'b10, 0, 2'b00));
      @(posedge clk); #1;
      expect_reset("rst_cycle1");
      @(posedge clk); #1;
      expect_reset("rst_cycle2");
      @(posedge clk); #1;
      reset = 1'b1;

      run_instr(32'hE0921003, 1, 4'b0100, -1);  // ADDS, Z set
      run_instr(32'h0A000002, 0, 4'h0, -1);     // BEQ taken
      run_instr(32'hE0521003, 1, 4'b0100, -1);  // SUBS, Z set
      run_instr(32'h0A000002, 0, 4'h0, -1);     // BEQ taken
      run_instr(32'h1A000002, 0, 4'h0, -1);     // BNE not taken
      run_instr(32'hE5910004, 0, 4'h0, -1);     // LDR
      run_instr(32'hE5810004, 0, 4'h0, -1);     // STR
      run_instr(32'hE18CF002, 0, 4'h0, -1);     // ORR PC, AL
      run_instr(32'hE0921003, 1, 4'b0000, -1);  // ADDS, Z clear
      run_instr(32'h018CF002, 0, 4'h0, -1);     // ORREQ PC, fails
      run_instr(32'h1A000002, 0, 4'h0, -1);     // BNE taken: flags unchanged
      run_instr(32'hEC000000, 0, 4'h0, -1);     // undefined
      run_instr(32'hE0921003, 1, 4'b0110, -1);  // ADDS, Z set again
      run_instr(32'hE5910004, 0, 4'h0, 3);      // LDR aborted in MEMRD
      run_instr(32'h0A000002, 0, 4'h0, -1);     // BEQ not taken: flags cleared
      run_instr(32'h1A000002, 0, 4'h0, -1);     // BNE taken

      for (int k = 0; k < 300; k++) begin
         w = $urandom;
         if ($urandom_range(0, 1) == 0) w[31:28] = 4'hE;
         if ($urandom_range(0, 7) == 0) w[15:12] = 4'hF;
         run_instr(w, 0, 4'h0, ($urandom_range(0, 39) == 0) ? 3 : -1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
